// File: rtl/icache.sv
// Direct-mapped, one-word-per-block read-only instruction cache.
// Hits are served combinationally; a miss is filled through IDLE/FILL.
module icache #(
  parameter int SETS   = 16,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  output logic              ihit,
  output logic [ADDR_W-1:0] imemload,
  output logic              iREN,
  output logic [ADDR_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [ADDR_W-1:0] iload,
  output logic [31:0]       miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int WA_W  = ADDR_W - 2;

  typedef enum logic {IDLE, FILL} state_e;

  state_e            state_q;
  logic [WA_W-1:0]   fill_wa_q;
  logic [31:0]       miss_count_q;
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [ADDR_W-1:0] data_q [SETS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             hit;
  logic             miss;
  logic             fill_done;
  logic             unused;

  assign unused   = ^imemaddr[1:0];
  assign idx      = imemaddr[IDX_W+1:2];
  assign tag      = imemaddr[ADDR_W-1:IDX_W+2];
  assign fill_idx = fill_wa_q[IDX_W-1:0];
  assign fill_tag = fill_wa_q[WA_W-1:IDX_W];

  always_comb begin
    hit       = 1'b0;
    miss      = 1'b0;
    fill_done = 1'b0;
    if (state_q == IDLE) begin
      hit  = imemREN & valid_q[idx] & (tag_q[idx] == tag);
      miss = imemREN & ~hit;
    end else begin
      fill_done = ~iwait;
    end
  end

  assign ihit       = hit;
  assign imemload   = hit ? data_q[idx] : '0;
  assign iREN       = (state_q == FILL);
  assign iaddr      = iREN ? {fill_wa_q, 2'b00} : '0;
  assign miss_count = miss_count_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      fill_wa_q    <= '0;
      miss_count_q <= '0;
      valid_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (miss) begin
            state_q   <= FILL;
            fill_wa_q <= imemaddr[ADDR_W-1:2];
            if (miss_count_q != 32'hFFFF_FFFF)
              miss_count_q <= miss_count_q + 32'd1;
          end
        end
        FILL: begin
          if (fill_done) begin
            state_q           <= IDLE;
            valid_q[fill_idx] <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag/data need no reset: a frame is only read once its valid bit is set.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: stimulus pushes expected hit words,
// a negedge monitor pops and compares them whenever ihit is seen.
module tb_icache;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] miss_count;

  typedef struct {
    logic [31:0] d;
    logic [31:0] mc;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;

  icache dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .ihit      (ihit),
    .imemload  (imemload),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
    .miss_count(miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (nRST && ihit) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_hit: got addr %h expected no hit", imemaddr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hit_data", imemload, e.d);
        chk("hit_miss_count", miss_count, e.mc);
      end
    end
  end

  // Called at posedge+#1 with the cache in IDLE; returns at posedge+#1.
  task automatic do_read(input logic [31:0] a, input bit miss,
                         input int waits, input logic [31:0] d,
                         input logic [31:0] mc);
    imemREN  = 1'b1;
    imemaddr = a;
    iload    = d;
    iwait    = (waits > 0);
    sb.push_back('{d: d, mc: mc});
    if (!miss) begin
      @(negedge CLK);
      chk("hit_now_ihit", {31'd0, ihit}, 32'd1);
      chk("hit_now_iren", {31'd0, iREN}, 32'd0);
    end else begin
      @(negedge CLK);
      chk("miss_ihit", {31'd0, ihit}, 32'd0);
      chk("miss_iren", {31'd0, iREN}, 32'd0);
      for (int k = 0; k <= waits; k++) begin
        @(posedge CLK);
        #1 iwait = (k < waits);
        @(negedge CLK);
        chk("fill_iren", {31'd0, iREN}, 32'd1);
        chk("fill_iaddr", iaddr, {a[31:2], 2'b00});
        chk("fill_ihit", {31'd0, ihit}, 32'd0);
        chk("fill_load", imemload, 32'd0);
      end
      @(negedge CLK);
      chk("after_fill_ihit", {31'd0, ihit}, 32'd1);
      chk("after_fill_iren", {31'd0, iREN}, 32'd0);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = '0;
    iwait    = 1'b1;
    iload    = '0;
    #12;
    chk("rst_ihit", {31'd0, ihit}, 32'd0);
    chk("rst_load", imemload, 32'd0);
    chk("rst_iren", {31'd0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_mc", miss_count, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    do_read(32'h40, 1, 0, 32'h3C01_0001, 32'd1);
    do_read(32'h42, 0, 0, 32'h3C01_0001, 32'd1);
    do_read(32'h80, 1, 3, 32'hDEAD_BEEF, 32'd2);
    do_read(32'h80, 0, 0, 32'hDEAD_BEEF, 32'd2);
    do_read(32'h40, 1, 0, 32'h3C01_0001, 32'd3);
    do_read(32'h44, 1, 1, 32'h0000_4444, 32'd4);

    // Redirect during a fill: the fill still completes to 0x100.
    imemREN  = 1'b1;
    imemaddr = 32'h100;
    iwait    = 1'b1;
    iload    = 32'h0100_0100;
    @(negedge CLK);
    chk("redir_miss_iren", {31'd0, iREN}, 32'd0);
    @(posedge CLK);
    #1 imemaddr = 32'h200;
    @(negedge CLK);
    chk("redir_iaddr0", iaddr, 32'h100);
    chk("redir_mc", miss_count, 32'd5);
    @(posedge CLK);
    #1 iwait = 1'b0;
    @(negedge CLK);
    chk("redir_iaddr1", iaddr, 32'h100);
    chk("redir_ihit", {31'd0, ihit}, 32'd0);
    @(posedge CLK);
    #1;
    do_read(32'h200, 1, 0, 32'h0200_0200, 32'd6);
    do_read(32'h44, 0, 0, 32'h0000_4444, 32'd6);
    do_read(32'h200, 0, 0, 32'h0200_0200, 32'd6);

    // No request: no hit, no fill, iwait low ignored.
    imemREN  = 1'b0;
    imemaddr = 32'h44;
    iwait    = 1'b0;
    @(negedge CLK);
    chk("noreq_ihit", {31'd0, ihit}, 32'd0);
    chk("noreq_load", imemload, 32'd0);
    chk("noreq_iren", {31'd0, iREN}, 32'd0);
    imemaddr = 32'h3F0;
    @(negedge CLK);
    chk("noreq_iren2", {31'd0, iREN}, 32'd0);
    chk("noreq_mc", miss_count, 32'd6);
    @(posedge CLK);
    #1;

    // Reset in the middle of a fill of 0x300.
    imemREN  = 1'b1;
    imemaddr = 32'h300;
    iwait    = 1'b1;
    iload    = 32'h0300_0300;
    @(negedge CLK);
    chk("rstfill_idle_iren", {31'd0, iREN}, 32'd0);
    @(negedge CLK);
    chk("rstfill_iren", {31'd0, iREN}, 32'd1);
    chk("rstfill_mc", miss_count, 32'd7);
    #2 nRST = 1'b0;
    #1;
    chk("rstmid_iren", {31'd0, iREN}, 32'd0);
    chk("rstmid_iaddr", iaddr, 32'd0);
    chk("rstmid_ihit", {31'd0, ihit}, 32'd0);
    chk("rstmid_mc", miss_count, 32'd0);
    iwait   = 1'b0;
    imemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    do_read(32'h300, 1, 0, 32'h0300_0300, 32'd1);
    do_read(32'h44, 1, 0, 32'h0000_4444, 32'd2);
    do_read(32'h40, 1, 2, 32'h3C01_0001, 32'd3);

    imemREN = 1'b0;
    @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
